// File: rtl/uart_rx_fifo_writer.sv
// UART 8N1 receiver that pushes each good byte into the receive fifo write port.
// Framing errors and overruns (good byte dropped because the fifo is full) are
// reported as one-cycle pulses.
//
// Fifo write port: din is valid only in the cycle write_en is high. The fifo must
// accept that push in the same cycle. There is no backpressure beyond full, and full
// is looked at only in the cycle the stop bit is sampled.
module uart_rx_fifo_writer #(
  parameter int CLKS_PER_BIT = 868,
  parameter int DATA_WIDTH   = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rx,
  input  logic                  full,
  output logic                  write_en,
  output logic [DATA_WIDTH-1:0] din,
  output logic                  frame_err,
  output logic                  overrun,
  output logic                  busy
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = $clog2(DATA_WIDTH + 1);

  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t                  state_q, state_d;
  logic                    sync1_q, sync1_d;
  logic                    sync2_q, sync2_d;
  logic                    rx_q, rx_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [IDX_W-1:0]        bit_idx_q, bit_idx_d;
  logic [DATA_WIDTH-1:0]   shift_q, shift_d;
  logic                    write_en_q, write_en_d;
  logic [DATA_WIDTH-1:0]   din_q, din_d;
  logic                    frame_err_q, frame_err_d;
  logic                    overrun_q, overrun_d;
  logic                    rx_s;

  // Synchronised serial input; all edge detection uses rx_s against rx_q.
  assign rx_s = sync2_q;

  // State register plus synchroniser, counters, shifter and output pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      rx_q        <= 1'b1;
      cnt_q       <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      write_en_q  <= 1'b0;
      din_q       <= '0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      rx_q        <= rx_d;
      cnt_q       <= cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      write_en_q  <= write_en_d;
      din_q       <= din_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  // Next-state logic: start detection, mid-bit sampling and the stop-bit verdict.
  always_comb begin
    state_d     = state_q;
    sync1_d     = rx;
    sync2_d     = sync1_q;
    rx_d        = rx_s;
    cnt_d       = cnt_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    write_en_d  = 1'b0;
    din_d       = din_q;
    frame_err_d = 1'b0;
    overrun_d   = 1'b0;

    case (state_q)
      IDLE: begin
        // Only a high-to-low transition starts a frame, so a line held low is ignored.
        if (rx_q && !rx_s) begin
          cnt_d   = '0;
          state_d = START;
        end
      end
      START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d = '0;
          if (!rx_s) begin
            bit_idx_d = '0;
            state_d   = DATA;
          end else begin
            // The line went high again before mid start bit, so this was a glitch.
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DATA: begin
        if (cnt_q == BIT_LAST) begin
          // LSB arrives first; shifting in at the MSB leaves it at bit 0.
          shift_d = {rx_s, shift_q[DATA_WIDTH-1:1]};
          cnt_d   = '0;
          if (bit_idx_q == IDX_LAST) begin
            state_d = STOP;
          end else begin
            bit_idx_d = bit_idx_q + IDX_W'(1);
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      STOP: begin
        if (cnt_q == BIT_LAST) begin
          // Leave at mid stop bit so a back-to-back start bit is still caught.
          state_d = IDLE;
          cnt_d   = '0;
          if (rx_s) begin
            if (full) begin
              overrun_d = 1'b1;
            end else begin
              write_en_d = 1'b1;
              din_d      = shift_q;
            end
          end else begin
            frame_err_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign write_en  = write_en_q;
  assign din       = din_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_fifo_writer.sv
// Bench for uart_rx_fifo_writer at 16 clk/bit: directed scenarios followed by
// random frames, with every output event compared against an expected queue.
module tb_uart_rx_fifo_writer;

  localparam int CPB = 16;
  localparam int DW  = 8;

  // Event encoding: {write_en, frame_err, overrun, data (only for writes)}.
  localparam int EW = 3 + DW;

  logic          clk;
  logic          reset;
  logic          rx;
  logic          full;
  logic          write_en;
  logic [DW-1:0] din;
  logic          frame_err;
  logic          overrun;
  logic          busy;

  int            n_checks;
  int            n_fail;
  int            cyc;
  logic [EW-1:0] exp_q[$];
  int            wr_cyc_q[$];

  uart_rx_fifo_writer #(
    .CLKS_PER_BIT(CPB),
    .DATA_WIDTH  (DW)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .rx       (rx),
    .full     (full),
    .write_en (write_en),
    .din      (din),
    .frame_err(frame_err),
    .overrun  (overrun),
    .busy     (busy)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Scoreboard: every cycle with an active output is one event, so a pulse that
  // lasts two cycles shows up as an extra, unexpected event.
  always @(negedge clk) begin
    logic [EW-1:0] obs;
    if (!reset && (write_en || frame_err || overrun)) begin
      obs = {write_en, frame_err, overrun, (write_en ? din : {DW{1'b0}})};
      if (write_en) wr_cyc_q.push_back(cyc);
      if (exp_q.size() == 0) begin
        check("unexpected_event", 32'(obs), 32'(0));
      end else begin
        check("event", 32'(obs), 32'(exp_q.pop_front()));
      end
    end
  end

  // Driver tasks
  task automatic wait_cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic drive_bit(input logic v);
    rx = v;
    wait_cycles(CPB);
  endtask

  // Reference model: the outcome of a frame depends only on the stop bit level
  // and the fifo full flag while the frame is on the line.
  task automatic send_frame(input logic [DW-1:0] b, input bit stop_ok, input int gap_bits);
    if (!stop_ok)  exp_q.push_back({3'b010, {DW{1'b0}}});
    else if (full) exp_q.push_back({3'b001, {DW{1'b0}}});
    else           exp_q.push_back({3'b100, b});
    drive_bit(1'b0);
    for (int i = 0; i < DW; i++) drive_bit(b[i]);
    drive_bit(stop_ok ? 1'b1 : 1'b0);
    for (int i = 0; i < gap_bits; i++) drive_bit(1'b1);
  endtask

  task automatic wait_drain(input string tag);
    int i;
    i = 0;
    while (exp_q.size() != 0 && i < 20 * CPB) begin
      @(negedge clk);
      i++;
    end
    check(tag, 32'(exp_q.size()), 32'(0));
  endtask

  initial begin
    int t0;
    n_checks = 0;
    n_fail   = 0;
    cyc      = 0;
    reset    = 1'b1;
    rx       = 1'b1;
    full     = 1'b0;
    wait_cycles(4);
    check("reset_outputs", {27'd0, write_en, frame_err, overrun, busy, |din}, 32'd0);
    reset = 1'b0;
    wait_cycles(4);
    check("idle_busy", 32'(busy), 32'd0);

    // 1: plain byte
    send_frame(8'hA5, 1'b1, 1);
    wait_drain("t1_drain");

    // 2: short glitch, then a real byte
    rx = 1'b0;
    wait_cycles(3);
    rx = 1'b1;
    wait_cycles(2);
    check("t2_busy_in_start", 32'(busy), 32'd1);
    wait_cycles(15);
    check("t2_busy_after_glitch", 32'(busy), 32'd0);
    wait_cycles(CPB);
    send_frame(8'h3C, 1'b1, 1);
    wait_drain("t2_drain");

    // 3: framing error, then held-low line must not retrigger
    send_frame(8'h3C, 1'b0, 0);
    wait_drain("t3_ferr_drain");
    wait_cycles(5 * CPB);
    check("t3_held_low_busy", 32'(busy), 32'd0);
    rx = 1'b1;
    wait_cycles(CPB);
    check("t3_after_rise_busy", 32'(busy), 32'd0);
    send_frame(8'h3C, 1'b1, 1);
    wait_drain("t3_drain");

    // 4: overrun while full, then a normal write
    full = 1'b1;
    send_frame(8'h55, 1'b1, 1);
    wait_drain("t4_ovr_drain");
    full = 1'b0;
    send_frame(8'h56, 1'b1, 1);
    wait_drain("t4_drain");

    // 5: back-to-back frames with no idle bits
    wr_cyc_q.delete();
    send_frame(8'h00, 1'b1, 0);
    send_frame(8'hFF, 1'b1, 1);
    wait_drain("t5_drain");
    check("t5_write_count", 32'(wr_cyc_q.size()), 32'd2);
    if (wr_cyc_q.size() == 2) begin
      t0 = wr_cyc_q[1] - wr_cyc_q[0];
      check("t5_spacing", 32'(t0), 32'd160);
    end

    // 6: reset in the middle of the data bits
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(i == 0 ? 1'b1 : 1'b0);
    @(negedge clk);
    reset = 1'b1;
    wait_cycles(2);
    check("t6_outputs_in_reset", {27'd0, write_en, frame_err, overrun, busy, |din}, 32'd0);
    rx = 1'b1;
    wait_cycles(2);
    reset = 1'b0;
    wait_cycles(6 * CPB);
    check("t6_no_event", 32'(exp_q.size()), 32'd0);
    check("t6_busy", 32'(busy), 32'd0);
    send_frame(8'h81, 1'b1, 1);
    wait_drain("t6_drain");

    // Random frames: data, stop bit, full and gap all randomised.
    for (int n = 0; n < 24; n++) begin
      logic [DW-1:0] b;
      bit            ok;
      int            gap;
      b    = DW'($urandom_range(0, 255));
      ok   = ($urandom_range(0, 4) != 0);
      full = ($urandom_range(0, 3) == 0);
      gap  = ok ? int'($urandom_range(0, 2)) : int'($urandom_range(1, 2));
      send_frame(b, ok, gap);
    end
    wait_drain("rand_drain");
    full = 1'b0;
    wait_cycles(4 * CPB);
    check("final_busy", 32'(busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
